cycle_sequencer: RTL and testbench

//  Parametrised M/T-cycle sequencer for the CPU core: owns the fetch, CB-prefix, execute, HALT and

---
 rtl/cycle_sequencer_pkg.sv | 18 +
 rtl/cycle_sequencer_tcount.sv | 19 +
 rtl/cycle_sequencer.sv | 86 ++++++++
 tb/tb_cycle_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cycle_sequencer_pkg.sv
// cycle_sequencer_pkg: state encoding, opcode constants and limit helper for the M/T-cycle sequencer
// Shared by cycle_sequencer and its testless clients; CYCLE_SEQ_WAIT_EN is handled in the top.
package cycle_sequencer_pkg;
  typedef enum logic [2:0] {
    SEQ_FETCH,
    SEQ_CB_FETCH,
    SEQ_EXEC,
    SEQ_HALT,
    SEQ_IRQ
  } seq_state_e;
  localparam logic [7:0] OPC_CB_PREFIX = 8'hCB;
  // Instruction length in M-cycles: clamped to 1..max_m, and a CB opcode always spans both fetches.
  function automatic logic [3:0] clamp_limit(input logic [3:0] req, input logic [3:0] max_m, input logic cb);
    logic [3:0] l;
    l = req == 4'd0 ? 4'd1 : req > max_m ? max_m : req;
    return cb && l < 4'd2 ? 4'd2 : l;
  endfunction
endpackage

// File: rtl/cycle_sequencer_tcount.sv
// seq_tcount: T-cycle counter with hold and wrap, carry marks the last T of an M-cycle
// Ports: clock, reset (sync, active-high), clear (force T0), hold (freeze count),
//        t (current T index), carry (advance the M-cycle counter this clock).
module seq_tcount #(
  parameter int T_PER_M = 4,
  localparam int TW = $clog2(T_PER_M)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          hold,
  output logic [TW-1:0] t,
  output logic          carry
);
  assign carry = !clear && !hold && t == TW'(T_PER_M - 1);
  always_ff @(posedge clock)
    if (reset || clear) t <= '0;
    else if (!hold) t <= carry ? '0 : t + TW'(1);
endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: M/T-cycle sequencer for fetch, CB-prefix, execute, HALT and interrupt entry
// Ports: clock, reset (sync, active-high); instruction, m_cycles_req, halt_req from IR/decoder;
//        mem_ready (bus wait), irq_pending, ime; m_cycle, t_cycle, cb, fetch strobes
//        (fetch_addr_ld, fetch_pc_inc, ir_load), instr_done, halted, irq_ack.
// Build option: define CYCLE_SEQ_WAIT_EN to stretch T1 while mem_ready is low; otherwise mem_ready is ignored.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int T_PER_M = 4,
  parameter int M_MAX = 6,
  parameter int IRQ_M_CYCLES = 5,
  localparam int MW = $clog2(M_MAX),
  localparam int TW = $clog2(T_PER_M)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    instruction,
  input  logic [3:0]    m_cycles_req,
  input  logic          halt_req,
  input  logic          mem_ready,
  input  logic          irq_pending,
  input  logic          ime,
  output logic [MW-1:0] m_cycle,
  output logic [TW-1:0] t_cycle,
  output logic          cb,
  output logic          fetch_addr_ld,
  output logic          fetch_pc_inc,
  output logic          ir_load,
  output logic          instr_done,
  output logic          halted,
  output logic          irq_ack
);
  seq_state_e state, state_n;
  logic [MW-1:0] m_n;
  logic [3:0] lim;
  logic cb_n, hold, carry, fin, irq_fin, fetch_ph, is_cb;
`ifdef CYCLE_SEQ_WAIT_EN
  assign hold = t_cycle == TW'(1) && !mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign hold = 1'b0;
`endif
  seq_tcount #(.T_PER_M(T_PER_M)) u_tcount (
    .clock(clock),
    .reset(reset),
    .clear(state == SEQ_HALT),
    .hold(hold),
    .t(t_cycle),
    .carry(carry)
  );
  assign is_cb = instruction == OPC_CB_PREFIX;
  assign lim = clamp_limit(m_cycles_req, 4'(M_MAX), cb);
  // >= rather than == keeps m_cycle bounded even if the decoder shrinks the count mid-instruction
  assign fin = carry && ((state == SEQ_FETCH && !is_cb && lim == 4'd1) ||
                         (state == SEQ_CB_FETCH && lim <= 4'd2) ||
                         (state == SEQ_EXEC && 4'(m_cycle) >= lim - 4'd1));
  assign irq_fin = carry && state == SEQ_IRQ && m_cycle == MW'(IRQ_M_CYCLES - 1);
  assign fetch_ph = state == SEQ_FETCH || state == SEQ_CB_FETCH;
  assign fetch_addr_ld = fetch_ph && t_cycle == TW'(0);
  assign fetch_pc_inc = fetch_ph && t_cycle == TW'(1);
  assign ir_load = fetch_ph && t_cycle == TW'(2);
  assign instr_done = fin;
  assign halted = state == SEQ_HALT;
  assign irq_ack = state == SEQ_IRQ && m_cycle == '0 && t_cycle == TW'(0);
  always_comb begin
    state_n = fin ? (irq_pending && ime ? SEQ_IRQ : halt_req ? SEQ_HALT : SEQ_FETCH)
            : irq_fin ? SEQ_FETCH
            : state == SEQ_HALT ? (!irq_pending ? SEQ_HALT : ime ? SEQ_IRQ : SEQ_FETCH)
            : !carry ? state
            : state == SEQ_FETCH ? (is_cb ? SEQ_CB_FETCH : SEQ_EXEC)
            : state == SEQ_CB_FETCH ? SEQ_EXEC : state;
    m_n = fin || irq_fin || state == SEQ_HALT ? '0 : carry ? m_cycle + MW'(1) : m_cycle;
    cb_n = fin ? 1'b0 : carry && state == SEQ_FETCH && is_cb ? 1'b1 : cb;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= SEQ_FETCH;
      m_cycle <= '0;
      cb <= 1'b0;
    end else begin
      state <= state_n;
      m_cycle <= m_n;
      cb <= cb_n;
    end
endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: randomized self-checking bench against a per-instruction timing model
module tb_cycle_sequencer;
  localparam int T = 4, MMAX = 6, IRQM = 5;
`ifdef CYCLE_SEQ_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, halt_req = 1'b0, mem_ready = 1'b1, irq_pending = 1'b0, ime = 1'b0;
  logic [7:0] instruction = 8'h00;
  logic [3:0] m_cycles_req = 4'd1;
  logic [2:0] m_cycle;
  logic [1:0] t_cycle;
  logic cb, fetch_addr_ld, fetch_pc_inc, ir_load, instr_done, halted, irq_ack;
  cycle_sequencer dut (
    .clock(clock), .reset(reset), .instruction(instruction), .m_cycles_req(m_cycles_req),
    .halt_req(halt_req), .mem_ready(mem_ready), .irq_pending(irq_pending), .ime(ime),
    .m_cycle(m_cycle), .t_cycle(t_cycle), .cb(cb), .fetch_addr_ld(fetch_addr_ld),
    .fetch_pc_inc(fetch_pc_inc), .ir_load(ir_load), .instr_done(instr_done),
    .halted(halted), .irq_ack(irq_ack)
  );
  always #5 clock = ~clock;
  typedef struct {
    bit rst;
    logic [7:0] ins;
    logic [3:0] req;
    bit hlt, rdy, irq, ime, chk;
    logic [11:0] exp;
  } rec_t;
  rec_t q[$];
  int checks = 0, errors = 0, wlo = 0, whi = 0, hlen = 0;
  bit hime = 1'b0;
  logic [11:0] obs;
  function automatic bit rb();
    return 1'($urandom);
  endfunction
  // expected output vector: {m, t, cb, addr_ld, pc_inc, ir_load, done, halted, ack}
  function automatic logic [11:0] ex(int m, int t, bit cbv, bit ad, bit inc, bit ir, bit dn, bit hl, bit ak);
    return {3'(m), 2'(t), cbv, ad, inc, ir, dn, hl, ak};
  endfunction
  function automatic void push(bit rst, bit hlt, bit rdy, bit irq, bit ie, logic [7:0] ins,
                               logic [3:0] req, logic [11:0] e, bit chk = 1'b1);
    rec_t r;
    r.rst = rst; r.hlt = hlt; r.rdy = rdy; r.irq = irq; r.ime = ie;
    r.ins = ins; r.req = req; r.exp = e; r.chk = chk;
    q.push_back(r);
  endfunction
  // One machine cycle: T_PER_M clocks, plus wait clocks at T1 when the wait build is active.
  function automatic void add_mcycle(int mi, bit fetch, bit cbv, bit ack, bit last, logic [7:0] op,
                                     logic [3:0] req, bit lirq, bit lime, bit lhlt);
    for (int t = 0; t < T; t++) begin
      bit f;
      logic [11:0] e;
      logic [7:0] ins;
      f = last && t == T - 1;
      e = ex(mi, t, cbv, fetch && t == 0, fetch && t == 1, fetch && t == 2, f, 1'b0, ack && t == 0);
      ins = (fetch && mi == 0 && t == T - 1) ? op : 8'($urandom);
      if (t == 1 && WAIT_EN)
        repeat ($urandom_range(whi, wlo)) push(1'b0, rb(), 1'b0, rb(), rb(), ins, req, e);
      push(1'b0, f ? lhlt : rb(), (t == 1 && WAIT_EN) ? 1'b1 : rb(), f ? lirq : rb(), f ? lime : rb(), ins, req, e);
    end
  endfunction
  function automatic void add_irq();
    for (int mi = 0; mi < IRQM; mi++)
      add_mcycle(mi, 1'b0, 1'b0, mi == 0, 1'b0, 8'($urandom), 4'($urandom), 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic void add_halt(int n, bit ie);
    for (int i = 0; i < n; i++)
      push(1'b0, rb(), rb(), 1'b0, rb(), 8'($urandom), 4'($urandom), ex(0, 0, 0, 0, 0, 0, 0, 1, 0));
    push(1'b0, rb(), rb(), 1'b1, ie, 8'($urandom), 4'($urandom), ex(0, 0, 0, 0, 0, 0, 0, 1, 0));
    if (ie) add_irq();
  endfunction
  function automatic void add_reset(bit chk);
    push(1'b1, rb(), rb(), rb(), rb(), 8'($urandom), 4'($urandom), ex(0, 0, 0, 1, 0, 0, 0, 0, 0), chk);
  endfunction
  // Whole instruction followed by whatever it dispatches to: IRQ beats HALT beats next fetch.
  function automatic void add_instr(logic [7:0] op, logic [3:0] req, bit lirq, bit lime, bit lhlt);
    bit iscb;
    int l;
    iscb = op == 8'hCB;
    l = req == 4'd0 ? 1 : int'(req) > MMAX ? MMAX : int'(req);
    if (iscb && l < 2) l = 2;
    for (int mi = 0; mi < l; mi++)
      add_mcycle(mi, mi == 0 || (iscb && mi == 1), iscb && mi >= 1, 1'b0, mi == l - 1, op, req, lirq, lime, lhlt);
    if (lirq && lime) add_irq();
    else if (lhlt) add_halt(hlen, hime);
  endfunction
  task automatic apply(input rec_t r);
    @(posedge clock);
    #1;
    reset = r.rst; instruction = r.ins; m_cycles_req = r.req; halt_req = r.hlt;
    mem_ready = r.rdy; irq_pending = r.irq; ime = r.ime;
    #1 obs = {m_cycle, t_cycle, cb, fetch_addr_ld, fetch_pc_inc, ir_load, instr_done, halted, irq_ack};
  endtask
  task automatic test_reset();
    q = {};
    add_reset(1'b0); add_reset(1'b1); add_reset(1'b1);
    add_instr(8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
    foreach (q[i]) begin
      apply(q[i]);
      if (q[i].chk) begin
        checks++;
        if (obs !== q[i].exp) begin errors++; $display("FAIL reset step %0d: got %b expected %b", i, obs, q[i].exp); end
      end
    end
  endtask
  task automatic test_nop();
    q = {};
    add_reset(1'b0);
    add_instr(8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
    add_instr(8'h3C, 4'd1, 1'b0, 1'b0, 1'b0);
    add_instr(8'h01, 4'd3, 1'b0, 1'b0, 1'b0);
    foreach (q[i]) begin
      apply(q[i]);
      if (q[i].chk) begin
        checks++;
        if (obs !== q[i].exp) begin errors++; $display("FAIL nop step %0d: got %b expected %b", i, obs, q[i].exp); end
      end
    end
  endtask
  task automatic test_cb();
    q = {};
    add_reset(1'b0);
    add_instr(8'hCB, 4'd4, 1'b0, 1'b0, 1'b0);
    add_instr(8'hCB, 4'd0, 1'b0, 1'b0, 1'b0);
    add_instr(8'hCB, 4'd1, 1'b0, 1'b0, 1'b0);
    add_instr(8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
    foreach (q[i]) begin
      apply(q[i]);
      if (q[i].chk) begin
        checks++;
        if (obs !== q[i].exp) begin errors++; $display("FAIL cb step %0d: got %b expected %b", i, obs, q[i].exp); end
      end
    end
  endtask
  task automatic test_clamp();
    q = {};
    add_reset(1'b0);
    add_instr(8'h21, 4'd9, 1'b0, 1'b0, 1'b0);
    add_instr(8'h21, 4'd15, 1'b0, 1'b0, 1'b0);
    add_instr(8'h21, 4'd6, 1'b0, 1'b0, 1'b0);
    add_instr(8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    add_instr(8'hCB, 4'd12, 1'b0, 1'b0, 1'b0);
    foreach (q[i]) begin
      apply(q[i]);
      if (q[i].chk) begin
        checks++;
        if (obs !== q[i].exp) begin errors++; $display("FAIL clamp step %0d: got %b expected %b", i, obs, q[i].exp); end
      end
    end
  endtask
  task automatic test_halt_irq();
    q = {};
    add_reset(1'b0);
    hlen = 10; hime = 1'b1;
    add_instr(8'h76, 4'd1, 1'b0, 1'b0, 1'b1);
    add_instr(8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
    hime = 1'b0;
    add_instr(8'h76, 4'd1, 1'b0, 1'b0, 1'b1);
    add_instr(8'h00, 4'd1, 1'b1, 1'b1, 1'b0);
    add_instr(8'h76, 4'd1, 1'b1, 1'b1, 1'b1);
    hlen = 0;
    add_instr(8'h76, 4'd1, 1'b1, 1'b0, 1'b1);
    add_instr(8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
    foreach (q[i]) begin
      apply(q[i]);
      if (q[i].chk) begin
        checks++;
        if (obs !== q[i].exp) begin errors++; $display("FAIL halt_irq step %0d: got %b expected %b", i, obs, q[i].exp); end
      end
    end
  endtask
  task automatic test_wait();
    q = {};
    add_reset(1'b0);
    wlo = 3; whi = 3;
    add_instr(8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
    wlo = 0; whi = 2;
    add_instr(8'hCB, 4'd3, 1'b1, 1'b1, 1'b0);
    add_instr(8'h00, 4'd2, 1'b0, 1'b0, 1'b0);
    wlo = 0; whi = 0;
    foreach (q[i]) begin
      apply(q[i]);
      if (q[i].chk) begin
        checks++;
        if (obs !== q[i].exp) begin errors++; $display("FAIL wait step %0d: got %b expected %b", i, obs, q[i].exp); end
      end
    end
  endtask
  task automatic test_reset_mid();
    q = {};
    add_reset(1'b0);
    add_instr(8'hCB, 4'd5, 1'b0, 1'b0, 1'b0);
    while (q.size() > 11) void'(q.pop_back());
    q[q.size() - 1].rst = 1'b1;
    add_instr(8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
    foreach (q[i]) begin
      apply(q[i]);
      if (q[i].chk) begin
        checks++;
        if (obs !== q[i].exp) begin errors++; $display("FAIL reset_mid step %0d: got %b expected %b", i, obs, q[i].exp); end
      end
    end
  endtask
  task automatic test_random();
    q = {};
    add_reset(1'b0);
    wlo = 0; whi = 3;
    for (int n = 0; n < 60; n++) begin
      hlen = $urandom_range(0, 6);
      hime = rb();
      add_instr($urandom_range(0, 3) == 0 ? 8'hCB : 8'($urandom), 4'($urandom),
                $urandom_range(0, 3) == 0, rb(), $urandom_range(0, 3) == 0);
    end
    wlo = 0; whi = 0;
    foreach (q[i]) begin
      apply(q[i]);
      if (q[i].chk) begin
        checks++;
        if (obs !== q[i].exp) begin errors++; $display("FAIL random step %0d: got %b expected %b", i, obs, q[i].exp); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_nop();
    test_cb();
    test_clamp();
    test_halt_irq();
    test_wait();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
